// File: rtl/relu_ctrl_pkg.sv
// Shared types and default sizing for the ReLU stream sequencer.
package relu_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_LANES      = 16;
  localparam int DEF_WORD_WIDTH = DEF_LANES * DEF_DATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR      = 3'd3,
    FIN     = 3'd4
  } state_e;

endpackage

// File: rtl/relu_stream_ctrl_lanes.sv
// Combinational ReLU lane array: negative lanes clamp to zero, others pass through.
module relu_stream_ctrl_lanes #(
  parameter int DATA_WIDTH = 8,
  parameter int LENGTH     = 16
) (
  input  logic [DATA_WIDTH-1:0] din  [LENGTH],
  output logic [DATA_WIDTH-1:0] dout [LENGTH]
);

  // Per-lane clamp on the sign bit
  always_comb begin
    for (int i = 0; i < LENGTH; i++) begin
      if (din[i][DATA_WIDTH-1]) begin
        dout[i] = {DATA_WIDTH{1'b0}};
      end else begin
        dout[i] = din[i];
      end
    end
  end

endmodule

// File: rtl/relu_stream_ctrl.sv
// Sequencer that streams a vector from the buffer through the ReLU lanes and writes it back.
module relu_stream_ctrl
  import relu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LANES      = DEF_LANES,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [ADDR_WIDTH-1:0]       src_addr,
  input  logic [ADDR_WIDTH-1:0]       dst_addr,
  input  logic [LEN_WIDTH-1:0]        length,
  output logic                        busy,
  output logic                        done,
  output logic                        rd_req,
  output logic [ADDR_WIDTH-1:0]       rd_addr,
  input  logic                        rd_ready,
  input  logic                        rd_valid,
  input  logic [LANES*DATA_WIDTH-1:0] rd_data,
  output logic                        wr_req,
  output logic [ADDR_WIDTH-1:0]       wr_addr,
  output logic [LANES*DATA_WIDTH-1:0] wr_data,
  output logic [LANES-1:0]            wr_mask,
  input  logic                        wr_ready
);

  localparam int WORD_W = LANES * DATA_WIDTH;
  localparam int EW     = LEN_WIDTH + 1;

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  k_q, k_d, len_q, len_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic                  rd_req_q, rd_req_d, wr_req_q, wr_req_d;
  logic [WORD_W-1:0]     wr_data_q, wr_data_d;
  logic [LANES-1:0]      wr_mask_q, wr_mask_d;

  logic [DATA_WIDTH-1:0] lane_in_s  [LANES];
  logic [DATA_WIDTH-1:0] lane_out_s [LANES];
  logic [WORD_W-1:0]     relu_word_s;
  logic [EW-1:0]         elem_base_s;
  logic [LANES-1:0]      chunk_mask_s;
  logic                  last_chunk_s;
  logic [LEN_WIDTH-1:0]  k_inc_s;

  relu_stream_ctrl_lanes #(
    .DATA_WIDTH(DATA_WIDTH),
    .LENGTH    (LANES)
  ) u_lanes (
    .din (lane_in_s),
    .dout(lane_out_s)
  );

  // Lane unpacking and chunk bookkeeping; EW bits keep k*LANES free of overflow
  always_comb begin
    relu_word_s  = {WORD_W{1'b0}};
    chunk_mask_s = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      lane_in_s[i] = rd_data[i*DATA_WIDTH +: DATA_WIDTH];
      relu_word_s[i*DATA_WIDTH +: DATA_WIDTH] = lane_out_s[i];
    end
    elem_base_s  = EW'(k_q) * EW'(LANES);
    for (int i = 0; i < LANES; i++) begin
      chunk_mask_s[i] = (elem_base_s + EW'(i)) < {1'b0, len_q};
    end
    last_chunk_s = (elem_base_s + EW'(LANES)) >= {1'b0, len_q};
    k_inc_s      = k_q + LEN_WIDTH'(1);
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    len_d     = len_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rd_req_d  = rd_req_q;
    wr_req_d  = wr_req_q;
    wr_data_d = wr_data_q;
    wr_mask_d = wr_mask_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          src_d  = src_addr;
          dst_d  = dst_addr;
          len_d  = length;
          k_d    = {LEN_WIDTH{1'b0}};
          busy_d = 1'b1;
          if (length == {LEN_WIDTH{1'b0}}) begin
            state_d = FIN;
          end else begin
            state_d   = RD_REQ;
            rd_req_d  = 1'b1;
            rd_addr_d = src_addr;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD_REQ: begin
        if (rd_ready) begin
          rd_req_d = 1'b0;
          state_d  = RD_WAIT;
        end else begin
          state_d = RD_REQ;
        end
      end
      RD_WAIT: begin
        if (rd_valid) begin
          wr_data_d = relu_word_s;
          wr_mask_d = chunk_mask_s;
          wr_addr_d = dst_q + ADDR_WIDTH'(k_q);
          wr_req_d  = 1'b1;
          state_d   = WR;
        end else begin
          state_d = RD_WAIT;
        end
      end
      WR: begin
        if (wr_ready) begin
          wr_req_d = 1'b0;
          if (last_chunk_s) begin
            state_d = FIN;
          end else begin
            k_d       = k_inc_s;
            rd_req_d  = 1'b1;
            rd_addr_d = src_q + ADDR_WIDTH'(k_inc_s);
            state_d   = RD_REQ;
          end
        end else begin
          state_d = WR;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        rd_req_d = 1'b0;
        wr_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any command in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= {LEN_WIDTH{1'b0}};
      len_q     <= {LEN_WIDTH{1'b0}};
      src_q     <= {ADDR_WIDTH{1'b0}};
      dst_q     <= {ADDR_WIDTH{1'b0}};
      rd_addr_q <= {ADDR_WIDTH{1'b0}};
      wr_addr_q <= {ADDR_WIDTH{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_req_q  <= 1'b0;
      wr_req_q  <= 1'b0;
      wr_data_q <= {WORD_W{1'b0}};
      wr_mask_q <= {LANES{1'b0}};
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      len_q     <= len_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_req_q  <= rd_req_d;
      wr_req_q  <= wr_req_d;
      wr_data_q <= wr_data_d;
      wr_mask_q <= wr_mask_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_req  = rd_req_q;
  assign rd_addr = rd_addr_q;
  assign wr_req  = wr_req_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_mask = wr_mask_q;

endmodule

// File: tb/tb_relu_stream_ctrl.sv
// Self-checking bench: transaction-level model of the expected read/write stream plus literal pins.
module tb_relu_stream_ctrl;

  localparam int DW = 8;
  localparam int LN = 16;
  localparam int AW = 16;
  localparam int LW = 16;
  localparam int WW = DW * LN;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start;
  logic [AW-1:0] src_addr, dst_addr;
  logic [LW-1:0] length;
  logic          busy, done, rd_req, rd_ready, rd_valid, wr_req, wr_ready;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [WW-1:0] rd_data, wr_data;
  logic [LN-1:0] wr_mask;

  int n_vec = 0;
  int n_err = 0;
  int rd_rdy_dly = 0;
  int rd_val_dly = 0;
  int wr_dly     = 0;
  bit done_armed = 1'b0;

  logic [AW-1:0] exp_rd[$];
  logic [AW-1:0] exp_wa[$];
  logic [WW-1:0] exp_wd[$];
  logic [LN-1:0] exp_wm[$];
  logic [AW-1:0] log_wa[$];
  logic [WW-1:0] log_wd[$];
  logic [LN-1:0] log_wm[$];
  logic [WW-1:0] mem [int];

  relu_stream_ctrl #(
    .DATA_WIDTH(DW), .LANES(LN), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .busy(busy), .done(done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_mask(wr_mask), .wr_ready(wr_ready)
  );

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] get_word(input logic [AW-1:0] a);
    logic [WW-1:0] w;
    if (mem.exists(int'(a))) return mem[int'(a)];
    for (int i = 0; i < LN; i++) w[i*DW +: DW] = 8'((int'(a) * 37 + i * 53 + 11));
    return w;
  endfunction

  function automatic logic [WW-1:0] relu_ref(input logic [WW-1:0] w);
    logic [WW-1:0] r;
    for (int i = 0; i < LN; i++) begin
      int v;
      v = int'($signed(w[i*DW +: DW]));
      r[i*DW +: DW] = (v < 0) ? 8'd0 : 8'(v);
    end
    return r;
  endfunction

  // Expected transaction stream for one command
  task automatic model_cmd(input int src, input int dst, input int len);
    int n;
    logic [LN-1:0] m;
    n = (len + LN - 1) / LN;
    for (int k = 0; k < n; k++) begin
      exp_rd.push_back(AW'(src + k));
      exp_wa.push_back(AW'(dst + k));
      exp_wd.push_back(relu_ref(get_word(AW'(src + k))));
      for (int i = 0; i < LN; i++) m[i] = ((k * LN + i) < len);
      exp_wm.push_back(m);
    end
    done_armed = 1'b1;
    log_wa.delete(); log_wd.delete(); log_wm.delete();
  endtask

  task automatic pulse_start(input int src, input int dst, input int len);
    src_addr = AW'(src); dst_addr = AW'(dst); length = LW'(len);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int c = 0; c < 3000 && done !== 1'b1; c++) begin
      @(posedge clk); #1;
    end
    chk({name, "_done_seen"}, {127'b0, done}, 1);
    chk({name, "_rd_left"}, exp_rd.size(), 0);
    chk({name, "_wr_left"}, exp_wa.size(), 0);
    @(posedge clk); #1;
    chk({name, "_done_1cyc"}, {127'b0, done}, 0);
  endtask

  task automatic run_cmd(input string name, input int src, input int dst, input int len);
    model_cmd(src, dst, len);
    pulse_start(src, dst, len);
    wait_done(name);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_busy"}, {127'b0, busy}, 0);
    chk({name, "_done"}, {127'b0, done}, 0);
    chk({name, "_rd_req"}, {127'b0, rd_req}, 0);
    chk({name, "_wr_req"}, {127'b0, wr_req}, 0);
    chk({name, "_rd_addr"}, rd_addr, 0);
    chk({name, "_wr_addr"}, wr_addr, 0);
    chk({name, "_wr_data"}, wr_data, 0);
    chk({name, "_wr_mask"}, wr_mask, 0);
  endtask

  // Read port responder
  initial begin
    logic [AW-1:0] a;
    rd_ready = 1'b0; rd_valid = 1'b0; rd_data = '0;
    forever begin
      @(posedge clk); #1;
      if (rd_req === 1'b1) begin
        repeat (rd_rdy_dly) begin @(posedge clk); #1; end
        a = rd_addr;
        rd_ready = 1'b1;
        @(posedge clk); #1;
        rd_ready = 1'b0;
        repeat (rd_val_dly) begin @(posedge clk); #1; end
        rd_valid = 1'b1;
        rd_data  = get_word(a);
        @(posedge clk); #1;
        rd_valid = 1'b0;
        rd_data  = {LN{8'hA5}};
      end
    end
  end

  // Write port responder
  initial begin
    wr_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (wr_req === 1'b1) begin
        repeat (wr_dly) begin @(posedge clk); #1; end
        wr_ready = 1'b1;
        @(posedge clk); #1;
        wr_ready = 1'b0;
      end
    end
  end

  // Compare process: every cycle a request or done is visible, match it against the model
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rd_req !== 1'b0) begin
        chk("busy_during_rd", {127'b0, busy}, 1);
        if (exp_rd.size() == 0) chk("rd_unexpected", {127'b0, rd_req}, 0);
        else begin
          chk("rd_addr", rd_addr, exp_rd[0]);
          if (rd_ready) void'(exp_rd.pop_front());
        end
      end
      if (wr_req !== 1'b0) begin
        chk("busy_during_wr", {127'b0, busy}, 1);
        if (exp_wa.size() == 0) chk("wr_unexpected", {127'b0, wr_req}, 0);
        else begin
          chk("wr_after_rd", exp_rd.size() + 1, exp_wa.size());
          chk("wr_addr", wr_addr, exp_wa[0]);
          chk("wr_data", wr_data, exp_wd[0]);
          chk("wr_mask", wr_mask, exp_wm[0]);
          if (wr_ready) begin
            log_wa.push_back(wr_addr); log_wd.push_back(wr_data); log_wm.push_back(wr_mask);
            void'(exp_wa.pop_front()); void'(exp_wd.pop_front()); void'(exp_wm.pop_front());
          end
        end
      end
      if (done !== 1'b0) begin
        chk("done_expected", {127'b0, done}, {127'b0, done_armed});
        chk("busy_at_done", {127'b0, busy}, 0);
        chk("done_queues_empty", exp_rd.size() + exp_wa.size(), 0);
        done_armed = 1'b0;
      end
    end
  end

  initial begin
    logic [WW-1:0] w;
    rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // zero length: busy next cycle, done one cycle after that, no traffic
    done_armed = 1'b1;
    pulse_start(16'h0020, 16'h0030, 0);
    chk("len0_busy", {127'b0, busy}, 1);
    chk("len0_done_early", {127'b0, done}, 0);
    @(posedge clk); #1;
    chk("len0_done", {127'b0, done}, 1);
    chk("len0_busy_off", {127'b0, busy}, 0);
    @(posedge clk); #1;
    chk("len0_done_pulse", {127'b0, done}, 0);

    // two full chunks; pin model and DUT log to literals
    model_cmd(16'h0010, 16'h0080, 32);
    chk("pin_rd0", exp_rd[0], 16'h0010);
    chk("pin_rd1", exp_rd[1], 16'h0011);
    chk("pin_wm1", exp_wm[1], 16'hFFFF);
    pulse_start(16'h0010, 16'h0080, 32);
    wait_done("full2");
    chk("full2_wa0", log_wa[0], 16'h0080);
    chk("full2_wa1", log_wa[1], 16'h0081);
    chk("full2_wm0", log_wm[0], 16'hFFFF);
    chk("full2_wm1", log_wm[1], 16'hFFFF);

    // partial last chunk
    run_cmd("len20", 16'h0200, 16'h0300, 20);
    chk("len20_wm0", log_wm[0], 16'hFFFF);
    chk("len20_wm1", log_wm[1], 16'h000F);

    // ReLU boundary lanes
    w = {LN{8'h05}};
    w[7:0] = 8'h80; w[15:8] = 8'hFF; w[23:16] = 8'h00; w[31:24] = 8'h01; w[39:32] = 8'h7F;
    mem[16'h0040] = w;
    run_cmd("lanes", 16'h0040, 16'h0041, 5);
    w = log_wd[0];
    chk("lanes_lo5", w[39:0], 40'h7F01000000);
    chk("lanes_mask", log_wm[0], 16'h001F);

    // slow handshakes
    rd_rdy_dly = 5; rd_val_dly = 3; wr_dly = 4;
    run_cmd("slow", 16'h0500, 16'h0600, 40);
    rd_rdy_dly = 0; rd_val_dly = 0; wr_dly = 0;

    // address wrap
    run_cmd("wrap", 16'hFFFF, 16'hFFFE, 40);
    chk("wrap_wa2", log_wa[2], 16'h0000);

    // start while busy is ignored
    model_cmd(16'h0700, 16'h0710, 48);
    pulse_start(16'h0700, 16'h0710, 48);
    @(posedge clk); #1;
    pulse_start(16'h0900, 16'h0910, 16);
    wait_done("busy_start");

    // reset while in WR aborts without done
    wr_dly = 3;
    model_cmd(16'h0A00, 16'h0B00, 64);
    pulse_start(16'h0A00, 16'h0B00, 64);
    for (int c = 0; c < 200 && wr_req !== 1'b1; c++) begin
      @(posedge clk); #1;
    end
    chk("abort_reached_wr", {127'b0, wr_req}, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_zero("abort");
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete(); exp_wm.delete();
    done_armed = 1'b0;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    wr_dly = 0;
    run_cmd("after_abort", 16'h0C00, 16'h0D00, 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
